// File: rtl/tero_select_seq_pkg.sv
// Shared types and the challenge-to-key fold for the TERO selection sequencer.
package tero_seq_pkg;

  typedef enum logic [1:0] {
    MODE_LINEAR = 2'd0,
    MODE_XOR    = 2'd1,
    MODE_STRIDE = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Fold a challenge into an idx_w-bit key: bit b lands on bit (b mod idx_w),
  // which is the XOR of idx_w-wide chunks with the last chunk zero-padded.
  // Narrow challenges simply come out zero-extended.
  function automatic logic [31:0] fold_key(input logic [31:0] challenge,
                                           input int chal_bits,
                                           input int idx_w);
    logic [31:0] k;
    k = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < chal_bits) k[5'(b % idx_w)] = k[5'(b % idx_w)] ^ challenge[b];
    end
    return k;
  endfunction

endpackage

// File: rtl/tero_select_seq_if.sv
// Index hand-off from the sequencer to the frequency counter.
interface tero_select_seq_if #(
  parameter int IDX_W  = 5,
  parameter int PASS_W = 3
);
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_valid;
  logic              sel_ready;
  logic [PASS_W-1:0] pass_idx;

  modport master (output sel_idx, output sel_valid, output pass_idx, input sel_ready);
  modport slave  (input sel_idx, input sel_valid, input pass_idx, output sel_ready);
endinterface

// File: rtl/tero_select_seq_idx_gen.sv
// Per-sweep index generator: step counter, stride accumulator and latched key.
// idx depends only on registers, so it stays stable while the consumer stalls.
module tero_idx_gen
  import tero_seq_pkg::*;
#(
  parameter int NUM_LOOPS = 32,
  parameter int IDX_W     = $clog2(NUM_LOOPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  mode_e            mode,
  input  logic [IDX_W-1:0] key_in,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W-1:0] i_q;
  logic [IDX_W-1:0] acc_q;
  logic [IDX_W-1:0] key_q;
  logic [IDX_W-1:0] stride;

  // Odd stride is coprime with a power-of-two ring count, so every sweep is a permutation.
  generate
    if (IDX_W > 1) begin : g_stride
      assign stride = {key_q[IDX_W-1:1], 1'b1};
    end else begin : g_stride1
      assign stride = 1'b1;
    end
  endgenerate

  assign last = (i_q == IDX_W'(NUM_LOOPS - 1));

  // Step counter and accumulator; the accumulator reloads the key at each sweep boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_q   <= '0;
      acc_q <= '0;
      key_q <= '0;
    end else if (load) begin
      i_q   <= '0;
      acc_q <= key_in;
      key_q <= key_in;
    end else if (step) begin
      if (last) begin
        i_q   <= '0;
        acc_q <= key_q;
      end else begin
        i_q   <= i_q + 1'b1;
        acc_q <= acc_q + stride;
      end
    end
  end

  // Index selection for the latched visiting order.
  always_comb begin
    case (mode)
      MODE_XOR:    idx = i_q ^ key_q;
      MODE_STRIDE: idx = acc_q;
      default:     idx = i_q;
    endcase
  end

endmodule

// File: rtl/tero_select_seq.sv
// Challenge-driven TERO selection sequencer: latches the run setup on start,
// walks the ring array in the selected order for n passes, and offers each
// index to the frequency counter over a valid/ready handshake.
module tero_select_seq
  import tero_seq_pkg::*;
#(
  parameter int NUM_LOOPS      = 32,
  parameter int CHALLENGE_BITS = 4,
  parameter int MAX_PASSES     = 4,
  localparam int IDX_W         = $clog2(NUM_LOOPS),
  localparam int PASS_W        = $clog2(MAX_PASSES) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [CHALLENGE_BITS-1:0] challenge_in,
  input  logic [PASS_W-1:0]         n_passes,
  tero_select_seq_if.master         sel,
  output logic                      busy,
  output logic                      done,
  output logic                      err_mode
);

  state_e            state_q;
  mode_e             mode_q;
  logic [PASS_W-1:0] passes_q;
  logic [PASS_W-1:0] pass_q;
  logic              valid_q;
  logic [PASS_W-1:0] passes_eff;
  logic [IDX_W-1:0]  key_in;
  logic              accept;
  logic              xfer;
  logic              last;

  assign accept = (state_q == S_IDLE) && start && (mode_e'(mode) != MODE_RSVD);
  assign xfer   = valid_q && sel.sel_ready;
  assign key_in = IDX_W'(fold_key(32'(challenge_in), CHALLENGE_BITS, IDX_W));

  // Clamp the requested pass count into 1..MAX_PASSES.
  always_comb begin
    passes_eff = n_passes;
    if (n_passes == '0)                          passes_eff = PASS_W'(1);
    else if (n_passes > PASS_W'(MAX_PASSES))     passes_eff = PASS_W'(MAX_PASSES);
  end

  tero_idx_gen #(
    .NUM_LOOPS (NUM_LOOPS),
    .IDX_W     (IDX_W)
  ) u_idx_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   (xfer),
    .mode   (mode_q),
    .key_in (key_in),
    .idx    (sel.sel_idx),
    .last   (last)
  );

  assign sel.sel_valid = valid_q;
  assign sel.pass_idx  = pass_q;

  // Run FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_LINEAR;
      passes_q <= '0;
      pass_q   <= '0;
      valid_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_mode <= 1'b0;
    end else begin
      done     <= 1'b0;
      err_mode <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (mode_e'(mode) == MODE_RSVD) begin
              err_mode <= 1'b1;
            end else begin
              mode_q   <= mode_e'(mode);
              passes_q <= passes_eff;
              pass_q   <= '0;
              valid_q  <= 1'b1;
              busy     <= 1'b1;
              state_q  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (xfer && last) begin
            if (pass_q == passes_q - 1'b1) begin
              valid_q <= 1'b0;
              done    <= 1'b1;
              state_q <= S_DONE;
            end else begin
              pass_q <= pass_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
